axil_i2c_regs: RTL
==================

AXIL_I2C_REGS -- requirements
Module: axil_i2c_regs

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, meaning the number of decoded byte-address bits (awaddr/araddr[ADDR_W-1:0]).
REQ-002 SHALL have parameter PRER_RST, default 16'hFFFF, meaning the prescale reset value.
REQ-003 SHALL have ports clk (in, 1, clock) and rstn (in, 1, reset); the one clock; reset is asynchronous and active-low.
REQ-004 SHALL have AW/W ports: awvalid in 1, awready out 1, awaddr in 32, wvalid in 1, wready out 1, wdata in 32, wstrb in 4.
REQ-005 SHALL have B ports: bvalid out 1, bready in 1, bresp out 2.
REQ-006 SHALL have AR/R ports: arvalid in 1, arready out 1, araddr in 32, rvalid out 1, rready in 1, rdata out 32, rresp out 2.
REQ-007 SHALL have core-side outputs: prer out 16 (prescale), core_en out 1, txr out 8, cmd_sta, cmd_sto, cmd_rd, cmd_wr, cmd_ack (out 1 each), cmd_valid out 1 (one-cycle command strobe), irq out 1.
REQ-008 SHALL have core-side inputs: rxr in 8, rxack in 1, busy in 1, al in 1, tip in 1, done in 1 (one-cycle pulse at command completion or arbitration loss).

Function
REQ-009 SHALL map: 0x00 PRER rw [15:0]; 0x04 CTR rw [7]=EN, [6]=IEN; 0x08 TXR rw [7:0]; 0x0C RXR ro; 0x10 CR wo [7]=STA,[6]=STO,[5]=RD,[4]=WR,[3]=ACK,[0]=IACK, reads 0; 0x14 SR ro [7]=RxACK,[6]=BUSY,[5]=AL,[1]=TIP,[0]=IF. Unused bits read 0.
REQ-010 SHALL decode on address bits [ADDR_W-1:2] only; offsets 0x18..0x1C are unmapped.
REQ-011 SHALL assert awready and wready together, for exactly one cycle, in the cycle after awvalid&wvalid are both sampled high while awready=0 and bvalid=0.
REQ-012 SHALL commit the write on the edge where awvalid&awready&wvalid&wready, and SHALL set bvalid on that same edge.
REQ-013 SHALL hold bvalid and bresp until bvalid&bready, then clear bvalid; no new AW/W acceptance while bvalid=1.
REQ-014 SHALL return bresp 2'b00 for mapped offsets (writes to RXR/SR are ignored) and 2'b10 (SLVERR) for unmapped offsets, with no state change.
REQ-015 SHALL apply wstrb per byte to PRER; CTR/TXR/CR update only when wstrb[0]=1.
REQ-016 SHALL assert arready for exactly one cycle after arvalid is sampled high while arready=0 and rvalid=0.
REQ-017 SHALL capture rdata on the AR handshake edge, set rvalid on that edge, and hold rdata/rresp/rvalid stable until rvalid&rready.
REQ-018 SHALL return rresp 2'b00 for mapped offsets and 2'b10 with rdata 0 for unmapped offsets.
REQ-019 SHALL pulse cmd_valid for one cycle on the cycle after a CR write with any of bits [7:4] set and EN=1, with the cmd_* outputs equal to the written bits during that cycle, and 0 otherwise.
REQ-020 SHALL ignore CR command bits when EN=0 (no cmd_valid); IACK is honoured regardless of EN.
REQ-021 SHALL set IF on done=1 and clear it on a CR write with IACK=1; if both occur in the same cycle, set wins.
REQ-022 SHALL drive irq = IF & IEN, registered (one cycle after IF changes).
REQ-023 SHALL pass status inputs into SR combinationally at read-capture time; no added latency beyond REQ-017.
REQ-024 SHALL handle read and write channels independently; simultaneous AR and AW/W acceptance is permitted.

Reset
REQ-025 SHALL on rstn=0 immediately clear awready, wready, bvalid, arready, rvalid, cmd_valid, all cmd_* outputs, irq, IF, CTR, TXR, rdata, bresp and rresp, and set PRER to PRER_RST.
REQ-026 SHALL abandon any in-flight transaction on reset; no response is issued for it after rstn rises.

Structure
REQ-027 SHALL take register offsets, CTR/CR/SR bit positions and the AXI resp codes (OKAY, SLVERR) from shared package i2c_regs_pkg.
REQ-028 SHALL be a single module with no sub-modules; the read mux is inline.

Verification
REQ-029 Reset, then read 0x00 -> rdata 0x0000FFFF, rresp 0; read 0x04 -> 0x0.
REQ-030 Write 0x00=0x1234_00C7 with wstrb 4'h1 -> prer=16'hFFC7; bresp 0; exactly one awready pulse.
REQ-031 Write CTR=0xC0, then CR=0x90 -> one-cycle cmd_valid with cmd_sta=1, cmd_wr=1; with EN=0 the same write -> no cmd_valid.
REQ-032 Pulse done with IEN=1 -> SR[0]=1, irq=1 next cycle; write CR=0x01 -> IF=0, irq=0; done and IACK in the same cycle -> IF stays 1.
REQ-033 Write 0x18 -> bresp 2'b10, no register change; read 0x1C -> rresp 2'b10, rdata 0.
REQ-034 Hold rready=0 for 5 cycles during a read of 0x0C with rxr=0xA5 -> rvalid and rdata 0xA5 held stable, second arvalid not accepted until completion.

Source files
------------

// File: rtl/i2c_regs_pkg.sv
// Shared definitions for the AXI4-Lite I2C register block.
// Holds the byte offsets of each register, the bit positions inside
// CTR/CR/SR, the AXI response codes, and a small offset decoder used by both
// the write and the read channel.
package i2c_regs_pkg;

  // Byte offsets of the mapped registers. Offsets are kept 32 bits wide so
  // the decoder can compare them against a zero-extended address.
  localparam logic [31:0] OFF_PRER = 32'h00;
  localparam logic [31:0] OFF_CTR  = 32'h04;
  localparam logic [31:0] OFF_TXR  = 32'h08;
  localparam logic [31:0] OFF_RXR  = 32'h0C;
  localparam logic [31:0] OFF_CR   = 32'h10;
  localparam logic [31:0] OFF_SR   = 32'h14;

  // CTR bits
  localparam int CTR_EN  = 7;
  localparam int CTR_IEN = 6;

  // CR bits
  localparam int CR_STA  = 7;
  localparam int CR_STO  = 6;
  localparam int CR_RD   = 5;
  localparam int CR_WR   = 4;
  localparam int CR_ACK  = 3;
  localparam int CR_IACK = 0;

  // SR bits
  localparam int SR_RXACK = 7;
  localparam int SR_BUSY  = 6;
  localparam int SR_AL    = 5;
  localparam int SR_TIP   = 1;
  localparam int SR_IF    = 0;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Register selected by an access.
  typedef enum logic [2:0] {
    SEL_PRER,
    SEL_CTR,
    SEL_TXR,
    SEL_RXR,
    SEL_CR,
    SEL_SR,
    SEL_NONE
  } reg_sel_e;

  // Maps a word-aligned byte offset to a register select. Anything that is
  // not one of the six registers selects SEL_NONE.
  function automatic reg_sel_e decode_off(input logic [31:0] off);
    case (off)
      OFF_PRER: return SEL_PRER;
      OFF_CTR:  return SEL_CTR;
      OFF_TXR:  return SEL_TXR;
      OFF_RXR:  return SEL_RXR;
      OFF_CR:   return SEL_CR;
      OFF_SR:   return SEL_SR;
      default:  return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/axil_i2c_regs.sv
// AXI4-Lite register front end for an I2C master core.
//
// Ports
//   clk, rstn                     : clock, asynchronous active-low reset
//   awvalid/awready/awaddr        : write address channel
//   wvalid/wready/wdata/wstrb     : write data channel (AW and W accepted together)
//   bvalid/bready/bresp           : write response channel
//   arvalid/arready/araddr        : read address channel
//   rvalid/rready/rdata/rresp     : read data channel
//   prer, core_en, txr            : configuration towards the bit/byte core
//   cmd_sta..cmd_ack, cmd_valid   : one-cycle command strobe with its bits
//   irq                           : registered interrupt (IF & IEN)
//   rxr, rxack, busy, al, tip     : status from the core, sampled on reads
//   done                          : one-cycle completion / arbitration-loss pulse
//
// Only address bits [ADDR_W-1:2] take part in decoding, so the register map
// aliases every 2**ADDR_W bytes.
import i2c_regs_pkg::*;

module axil_i2c_regs #(
  parameter int          ADDR_W   = 5,
  parameter logic [15:0] PRER_RST = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rstn,

  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,

  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,

  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,

  output logic [15:0] prer,
  output logic        core_en,
  output logic [7:0]  txr,
  output logic        cmd_sta,
  output logic        cmd_sto,
  output logic        cmd_rd,
  output logic        cmd_wr,
  output logic        cmd_ack,
  output logic        cmd_valid,
  output logic        irq,

  input  logic [7:0]  rxr,
  input  logic        rxack,
  input  logic        busy,
  input  logic        al,
  input  logic        tip,
  input  logic        done
);

  // Channel state
  logic        awready_reg;   // shared by awready and wready
  logic        bvalid_reg;
  logic [1:0]  bresp_reg;
  logic        arready_reg;
  logic        rvalid_reg;
  logic [31:0] rdata_reg;
  logic [1:0]  rresp_reg;

  // Register file
  logic [15:0] prer_reg;
  logic        ctr_en_reg;
  logic        ctr_ien_reg;
  logic [7:0]  txr_reg;
  logic        if_reg;
  logic        irq_reg;

  // Command strobe; cmd_reg holds {STA, STO, RD, WR, ACK}
  logic        cmd_valid_reg;
  logic [4:0]  cmd_reg;

  // Decode / datapath
  logic [31:0] wr_off;
  logic [31:0] rd_off;
  reg_sel_e    wr_sel;
  reg_sel_e    rd_sel;
  logic        wr_fire;
  logic        ar_fire;
  logic        cr_wr;
  logic        cmd_go;
  logic [7:0]  sr_val;
  logic [31:0] rd_mux;

  // Address bits outside the decoded window and the upper data lanes are
  // intentionally ignored.
  logic        unused_bits;
  assign unused_bits = ^{awaddr[31:ADDR_W], awaddr[1:0],
                         araddr[31:ADDR_W], araddr[1:0],
                         wdata[31:16], wstrb[3:2]};

  // ------------------------------------------------------------------
  // Address decode: keep only bits [ADDR_W-1:2], zero everything else.
  // ------------------------------------------------------------------
  always_comb begin
    wr_off = '0;
    rd_off = '0;
    wr_off[ADDR_W-1:2] = awaddr[ADDR_W-1:2];
    rd_off[ADDR_W-1:2] = araddr[ADDR_W-1:2];
  end

  assign wr_sel  = decode_off(wr_off);
  assign rd_sel  = decode_off(rd_off);

  assign wr_fire = awvalid & awready_reg & wvalid & awready_reg;
  assign ar_fire = arvalid & arready_reg;

  // CR takes effect only through byte lane 0.
  assign cr_wr   = wr_fire & (wr_sel == SEL_CR) & wstrb[0];
  // Command bits are only forwarded to the core while it is enabled.
  assign cmd_go  = cr_wr & ctr_en_reg &
                   (wdata[CR_STA] | wdata[CR_STO] | wdata[CR_RD] | wdata[CR_WR]);

  // ------------------------------------------------------------------
  // Write address/data and response channel
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      awready_reg <= 1'b0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
    end else begin
      // Ready is a single-cycle pulse; a new one is only offered once the
      // previous response has been taken.
      if (awready_reg) begin
        awready_reg <= 1'b0;
      end else if (awvalid && wvalid && !bvalid_reg) begin
        awready_reg <= 1'b1;
      end

      if (wr_fire) begin
        bvalid_reg <= 1'b1;
        bresp_reg  <= (wr_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_reg && bready) begin
        bvalid_reg <= 1'b0;
      end
    end
  end

  // ------------------------------------------------------------------
  // Writable registers. RXR/SR writes and unmapped writes fall through.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prer_reg    <= PRER_RST;
      ctr_en_reg  <= 1'b0;
      ctr_ien_reg <= 1'b0;
      txr_reg     <= '0;
    end else if (wr_fire) begin
      case (wr_sel)
        SEL_PRER: begin
          if (wstrb[0]) prer_reg[7:0]  <= wdata[7:0];
          if (wstrb[1]) prer_reg[15:8] <= wdata[15:8];
        end
        SEL_CTR: begin
          if (wstrb[0]) begin
            ctr_en_reg  <= wdata[CTR_EN];
            ctr_ien_reg <= wdata[CTR_IEN];
          end
        end
        SEL_TXR: begin
          if (wstrb[0]) txr_reg <= wdata[7:0];
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Command strobe, interrupt flag and registered irq
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmd_valid_reg <= 1'b0;
      cmd_reg       <= '0;
      if_reg        <= 1'b0;
      irq_reg       <= 1'b0;
    end else begin
      cmd_valid_reg <= cmd_go;
      cmd_reg       <= cmd_go ? {wdata[CR_STA], wdata[CR_STO], wdata[CR_RD],
                                 wdata[CR_WR], wdata[CR_ACK]} : 5'b0;

      // A completion in the same cycle as an acknowledge must not be lost,
      // so setting takes priority over clearing.
      if (done) begin
        if_reg <= 1'b1;
      end else if (cr_wr && wdata[CR_IACK]) begin
        if_reg <= 1'b0;
      end

      irq_reg <= if_reg & ctr_ien_reg;
    end
  end

  // ------------------------------------------------------------------
  // Read mux: status inputs go straight into SR so a read reflects the
  // core state at the capture edge.
  // ------------------------------------------------------------------
  always_comb begin
    sr_val           = '0;
    sr_val[SR_RXACK] = rxack;
    sr_val[SR_BUSY]  = busy;
    sr_val[SR_AL]    = al;
    sr_val[SR_TIP]   = tip;
    sr_val[SR_IF]    = if_reg;
  end

  always_comb begin
    rd_mux = '0;
    case (rd_sel)
      SEL_PRER: rd_mux[15:0] = prer_reg;
      SEL_CTR: begin
        rd_mux[CTR_EN]  = ctr_en_reg;
        rd_mux[CTR_IEN] = ctr_ien_reg;
      end
      SEL_TXR:  rd_mux[7:0] = txr_reg;
      SEL_RXR:  rd_mux[7:0] = rxr;
      SEL_SR:   rd_mux[7:0] = sr_val;
      default:  rd_mux = '0;   // CR reads 0, unmapped reads 0
    endcase
  end

  // ------------------------------------------------------------------
  // Read address and data channel
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
      rresp_reg   <= RESP_OKAY;
    end else begin
      if (arready_reg) begin
        arready_reg <= 1'b0;
      end else if (arvalid && !rvalid_reg) begin
        arready_reg <= 1'b1;
      end

      if (ar_fire) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= rd_mux;
        rresp_reg  <= (rd_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
      end else if (rvalid_reg && rready) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign awready   = awready_reg;
  assign wready    = awready_reg;
  assign bvalid    = bvalid_reg;
  assign bresp     = bresp_reg;
  assign arready   = arready_reg;
  assign rvalid    = rvalid_reg;
  assign rdata     = rdata_reg;
  assign rresp     = rresp_reg;

  assign prer      = prer_reg;
  assign core_en   = ctr_en_reg;
  assign txr       = txr_reg;
  assign cmd_valid = cmd_valid_reg;
  assign cmd_sta   = cmd_reg[4];
  assign cmd_sto   = cmd_reg[3];
  assign cmd_rd    = cmd_reg[2];
  assign cmd_wr    = cmd_reg[1];
  assign cmd_ack   = cmd_reg[0];
  assign irq       = irq_reg;

endmodule
